fft_frame_loader: RTL and testbench
===================================

Name: fft_frame_loader

Overview:
Streaming-to-parallel front end for top_fft. It accepts complex Q1.FRAC_BITS samples one per cycle over a valid/ready handshake and assembles them into POINT_FFT-sample frames in a two-bank (ping-pong) buffer. It presents each complete frame as the packed bus that drives top_fft data_i, using a frame_valid/frame_ready handshake. This lets the FFT consume one frame while the next frame fills.

Parameters:
POINT_FFT_POW2, 4, log2 of frame length; POINT_FFT = 1 << POINT_FFT_POW2 (16)
FRAC_BITS, 15, fractional bits; sample width = FRAC_BITS+1, signed two's complement

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  synchronous active-low reset
s_valid_i  in  1  input sample valid
s_ready_o  out  1  loader can accept a sample this cycle
s_re_i  in  FRAC_BITS+1  sample real part, signed
s_im_i  in  FRAC_BITS+1  sample imag part, signed
s_last_i  in  1  marks the final sample of a frame (framing check)
frame_o  out  [POINT_FFT-1:0][1:0][FRAC_BITS:0]  packed frame; [n][0]=Re, [n][1]=Im, n = arrival order; connects directly to top_fft data_i
frame_valid_o  out  1  frame_o holds a complete frame
frame_ready_i  in  1  consumer takes the frame this cycle
err_o  out  1  sticky framing error

Behaviour:
- State: two banks, bank[0..1], each with POINT_FFT x 2 registers; full[1:0]; wr_bank, rd_bank (1 bit each); wr_cnt (POINT_FFT_POW2 bits); err.
- Reset (rst_ni=0 at a clock edge): full=0, wr_bank=0, rd_bank=0, wr_cnt=0, err=0.
  - Resulting outputs: s_ready_o=0 during the reset cycle then 1, frame_valid_o=0, err_o=0.
  - Bank contents are not reset. frame_o is don't-care while frame_valid_o=0.
  - Reset mid-frame discards all partial and complete frames.
- s_ready_o = rst_ni && !full[wr_bank]. This is combinational on registered state only and never depends on s_valid_i.
- Accept = s_valid_i && s_ready_o. On accept: bank[wr_bank][wr_cnt] <= {s_re_i, s_im_i}.
- Accept with wr_cnt == POINT_FFT-1 completes the frame: full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0. s_last_i may be 0 or 1 here, with no error either way.
- Accept with wr_cnt < POINT_FFT-1:
  - s_last_i=0: wr_cnt <= wr_cnt+1.
  - s_last_i=1 (premature last): the sample is written but the frame is dropped. wr_cnt <= 0, full is unchanged, wr_bank is unchanged, err <= 1.
- frame_valid_o = full[rd_bank]. frame_o = bank[rd_bank], a mux of registers with no arithmetic.
- Consume = frame_valid_o && frame_ready_i: full[rd_bank] <= 0, rd_bank toggles.
- Handshake rules:
  - Once frame_valid_o=1, frame_o is stable until consumed.
  - s_valid_i may be held with no ready; the sample is not taken.
- Simultaneous completion and consume are legal and always target different banks. Both updates apply in the same cycle.
- Both banks full: s_ready_o=0 until a consume. On the cycle after the consume, s_ready_o=1.
- Latency: the accept of sample POINT_FFT-1 at edge t gives frame_valid_o=1 after edge t (0 extra cycles beyond the registered write).
- Throughput: with frame_ready_i held at 1, one sample is accepted every cycle indefinitely with no bubbles.
- err_o is sticky until reset.
- No width growth: widths are preserved exactly, with no rounding or saturation.

Decomposition:
- Shared package fft_pkg holds:
  - POINT_FFT derivation, POINT_FFT_POW2 and FRAC_BITS defaults.
  - sample_t (signed [FRAC_BITS:0]).
  - cplx_t ([1:0] sample_t, index 0=Re, 1=Im).
  - frame_t ([POINT_FFT-1:0] cplx_t).
  - The DATA_OUT_W formula shared with top_fft.
- One sub-module is natural: fft_frame_bank. It holds one bank's register array with a write enable, write index and write data, and outputs its frame_t. It is instantiated twice; the top module holds the counters, the full flags and the output mux.

Test Plan:
- DC frame: after reset, stream 16 samples with Re=16'sh4000 and Im=0, s_last_i on sample 15, frame_ready_i=0. Required: frame_valid_o rises the cycle after sample 15, and all frame_o[n][0]=16'sh4000, [n][1]=0.
- Ordering: stream Re=n, Im=-n for n=0..15. Required: frame_o[n]={n,-n}. Then connect to top_fft: bin 0 Re equals the sum 120 in Q format.
- Backpressure: with frame_ready_i=0, stream 40 samples back-to-back. Required: the first 32 are accepted, then s_ready_o=0 and valid is held. Pulse frame_ready_i once. Required: rd_bank toggles, s_ready_o=1 on the next cycle, and the frame from bank 1 appears intact.
- Continuous streaming: frame_ready_i=1 and 64 consecutive valid samples (4 frames). Required: s_ready_o is never 0, 4 consume pulses occur, and the completion and consume coincidence cycles lose no data.
- Premature last: assert s_last_i on sample 5. Required: err_o=1 and stays 1, no frame_valid_o. The next 16 samples form a correct frame starting at index 0.
- Mid-frame reset: reset after 9 samples with one full bank pending. Required: frame_valid_o=0 and err_o=0 after reset, and the next 16 samples yield one frame.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT sizing defaults, sample/frame types and output-width helper
package fft_pkg;

    localparam int DEF_POINT_FFT_POW2 = 4;
    localparam int DEF_FRAC_BITS      = 15;

    function automatic int point_fft(input int pow2);
        return 1 << pow2;
    endfunction

    localparam int DEF_POINT_FFT = point_fft(DEF_POINT_FFT_POW2);

    typedef logic signed [DEF_FRAC_BITS:0] sample_t;
    typedef sample_t [1:0]                  cplx_t;   // [0]=Re, [1]=Im
    typedef cplx_t [DEF_POINT_FFT-1:0]      frame_t;

    // top_fft grows one bit per radix-2 stage
    function automatic int data_out_w(input int frac_bits, input int pow2);
        return frac_bits + 1 + pow2;
    endfunction

    localparam int DATA_OUT_W = data_out_w(DEF_FRAC_BITS, DEF_POINT_FFT_POW2);

endpackage

// File: rtl/fft_frame_loader_if.sv
// rtl/fft_frame_loader_if.sv - sample stream in, packed frame out, sticky framing error
interface fft_frame_loader_if
    import fft_pkg::*;
#(
    parameter int POINT_FFT_POW2 = DEF_POINT_FFT_POW2,
    parameter int FRAC_BITS      = DEF_FRAC_BITS
);
    localparam int POINT_FFT = point_fft(POINT_FFT_POW2);

    logic                                       s_valid_i;
    logic                                       s_ready_o;
    logic signed [FRAC_BITS:0]                  s_re_i;
    logic signed [FRAC_BITS:0]                  s_im_i;
    logic                                       s_last_i;
    logic [POINT_FFT-1:0][1:0][FRAC_BITS:0]     frame_o;
    logic                                       frame_valid_o;
    logic                                       frame_ready_i;
    logic                                       err_o;

    modport slave (
        input  s_valid_i, s_re_i, s_im_i, s_last_i, frame_ready_i,
        output s_ready_o, frame_o, frame_valid_o, err_o
    );

    modport master (
        output s_valid_i, s_re_i, s_im_i, s_last_i, frame_ready_i,
        input  s_ready_o, frame_o, frame_valid_o, err_o
    );

endinterface

// File: rtl/fft_frame_bank.sv
// rtl/fft_frame_bank.sv - one frame of sample registers with indexed write port
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int POINT_FFT_POW2 = DEF_POINT_FFT_POW2,
    parameter int FRAC_BITS      = DEF_FRAC_BITS
) (
    input  logic                                                   clk_i,
    input  logic                                                   we_i,
    input  logic [POINT_FFT_POW2-1:0]                              idx_i,
    input  logic [FRAC_BITS:0]                                     re_i,
    input  logic [FRAC_BITS:0]                                     im_i,
    output logic [point_fft(POINT_FFT_POW2)-1:0][1:0][FRAC_BITS:0] frame_o
);
    localparam int POINT_FFT = point_fft(POINT_FFT_POW2);

    // Sample storage is deliberately unreset; full flags gate its visibility.
    logic [POINT_FFT-1:0][1:0][FRAC_BITS:0] mem_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i][0] <= re_i;
            mem_q[idx_i][1] <= im_i;
        end
    end

    assign frame_o = mem_q;

endmodule

// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - ping-pong assembly of streamed samples into top_fft frames
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int POINT_FFT_POW2 = DEF_POINT_FFT_POW2,
    parameter int FRAC_BITS      = DEF_FRAC_BITS
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    fft_frame_loader_if.slave  bus
);
    localparam int POINT_FFT = point_fft(POINT_FFT_POW2);
    localparam int CW        = POINT_FFT_POW2;
    localparam logic [CW-1:0] LAST_IDX = CW'(POINT_FFT - 1);

    typedef logic [POINT_FFT-1:0][1:0][FRAC_BITS:0] bank_frame_t;

    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic          err_q, err_d;

    logic          s_ready;
    logic          accept;
    logic          consume;
    bank_frame_t   bank_frame [2];

    assign s_ready = rst_ni && !full_q[wr_bank_q];
    assign accept  = bus.s_valid_i && s_ready;
    assign consume = full_q[rd_bank_q] && bus.frame_ready_i;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .POINT_FFT_POW2 (POINT_FFT_POW2),
            .FRAC_BITS      (FRAC_BITS)
        ) u_bank (
            .clk_i   (clk_i),
            .we_i    (accept && (wr_bank_q == 1'(b))),
            .idx_i   (wr_cnt_q),
            .re_i    (bus.s_re_i),
            .im_i    (bus.s_im_i),
            .frame_o (bank_frame[b])
        );
    end

    // Completion and consume never hit the same bank: a consumed bank is full,
    // and a full bank is never the write target.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        err_d     = err_q;
        if (consume) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (accept) begin
            if (wr_cnt_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_cnt_d          = '0;
            end else if (bus.s_last_i) begin
                // Short frame: drop what was written and restart at index 0.
                wr_cnt_d = '0;
                err_d    = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.s_ready_o     = s_ready;
    assign bus.frame_valid_o = full_q[rd_bank_q];
    assign bus.frame_o       = bank_frame[rd_bank_q];
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb/tb_fft_frame_loader.sv - randomized bench for fft_frame_loader against a frame-queue model
module tb_fft_frame_loader;
    typedef logic [15:0][1:0][15:0] frm_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_frame_loader_if bus ();

    fft_frame_loader dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: completed frames waiting in order, plus the frame being filled.
    frm_t q[$];
    frm_t cur;
    int   cnt = 0;
    bit   m_err = 1'b0;

    int dut_acc = 0;
    int dut_cons = 0;
    int ready_low = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_frame(input string name, input frm_t act, input frm_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("s_ready", 32'(bus.s_ready_o), 32'(rst_n && q.size() < 2));
        chk("frame_valid", 32'(bus.frame_valid_o), 32'(q.size() > 0));
        chk("err", 32'(bus.err_o), 32'(m_err));
        if (q.size() > 0) chk_frame("frame_data", bus.frame_o, q[0]);
    endtask

    task automatic step(input logic v, input logic [15:0] re, input logic [15:0] im,
                        input logic last, input logic fr, input logic rn);
        bit m_rdy;
        @(negedge clk);
        check_model();
        bus.s_valid_i     = v;
        bus.s_re_i        = re;
        bus.s_im_i        = im;
        bus.s_last_i      = last;
        bus.frame_ready_i = fr;
        rst_n             = rn;
        #1;
        if (!rn) chk("ready_in_reset", 32'(bus.s_ready_o), 32'd0);
        if (v && bus.s_ready_o) dut_acc++;
        if (bus.frame_valid_o && fr) dut_cons++;
        if (rn && !bus.s_ready_o) ready_low++;
        if (!rn) begin
            q.delete();
            cnt   = 0;
            m_err = 1'b0;
        end else begin
            m_rdy = (q.size() < 2);
            if (q.size() > 0 && fr) void'(q.pop_front());
            if (v && m_rdy) begin
                cur[cnt][0] = re;
                cur[cnt][1] = im;
                if (cnt == 15) begin
                    q.push_back(cur);
                    cnt = 0;
                end else if (last) begin
                    cnt   = 0;
                    m_err = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
    endtask

    task automatic idle(input logic fr);
        step(1'b0, 16'h0, 16'h0, 1'b0, fr, 1'b1);
    endtask

    task automatic rand_frame(input logic fr);
        for (int n = 0; n < 16; n++)
            step(1'b1, 16'($urandom), 16'($urandom), n == 15, fr, 1'b1);
    endtask

    initial begin
        logic ok;
        int   sum;
        bus.s_valid_i = 0; bus.s_re_i = 0; bus.s_im_i = 0;
        bus.s_last_i = 0; bus.frame_ready_i = 0;

        step(0, 0, 0, 0, 0, 1'b0);
        step(0, 0, 0, 0, 0, 1'b0);
        idle(0);
        chk("reset_ready", 32'(bus.s_ready_o), 32'd1);
        chk("reset_valid", 32'(bus.frame_valid_o), 32'd0);
        chk("reset_err", 32'(bus.err_o), 32'd0);

        // DC frame
        for (int n = 0; n < 16; n++) step(1, 16'sh4000, 16'h0, n == 15, 0, 1);
        idle(0);
        chk("dc_valid", 32'(bus.frame_valid_o), 32'd1);
        ok = 1'b1;
        for (int n = 0; n < 16; n++)
            if (bus.frame_o[n][0] !== 16'sh4000 || bus.frame_o[n][1] !== 16'h0) ok = 1'b0;
        chk("dc_contents", 32'(ok), 32'd1);
        idle(1);

        // Ordering
        for (int n = 0; n < 16; n++) step(1, 16'(n), 16'(-n), n == 15, 0, 1);
        idle(0);
        ok  = 1'b1;
        sum = 0;
        for (int n = 0; n < 16; n++) begin
            if (bus.frame_o[n][0] !== 16'(n) || bus.frame_o[n][1] !== 16'(-n)) ok = 1'b0;
            sum += int'($signed(bus.frame_o[n][0]));
        end
        chk("order_contents", 32'(ok), 32'd1);
        chk("order_re_sum", 32'(sum), 32'd120);
        idle(1);

        // Backpressure: 40 offered, only two frames fit
        dut_acc = 0;
        for (int n = 0; n < 40; n++)
            step(1, 16'($urandom), 16'($urandom), (n % 16) == 15, 0, 1);
        idle(0);
        chk("bp_accepted", 32'(dut_acc), 32'd32);
        chk("bp_ready_low", 32'(bus.s_ready_o), 32'd0);
        chk("bp_valid_held", 32'(bus.frame_valid_o), 32'd1);
        idle(1);
        idle(0);
        chk("bp_ready_after_consume", 32'(bus.s_ready_o), 32'd1);
        idle(1);
        idle(0);

        // Continuous streaming with the consumer always ready
        dut_cons  = 0;
        ready_low = 0;
        for (int f = 0; f < 4; f++) rand_frame(1);
        idle(1);
        idle(1);
        chk("stream_consumes", 32'(dut_cons), 32'd4);
        chk("stream_no_stall", 32'(ready_low), 32'd0);

        // Premature last on sample 5
        for (int n = 0; n < 6; n++) step(1, 16'($urandom), 16'($urandom), n == 5, 0, 1);
        idle(0);
        chk("early_err", 32'(bus.err_o), 32'd1);
        chk("early_no_valid", 32'(bus.frame_valid_o), 32'd0);
        rand_frame(0);
        idle(0);
        chk("early_then_frame", 32'(bus.frame_valid_o), 32'd1);
        chk("early_err_sticky", 32'(bus.err_o), 32'd1);
        idle(1);

        // Mid-frame reset with one full bank pending
        rand_frame(0);
        for (int n = 0; n < 9; n++) step(1, 16'($urandom), 16'($urandom), 0, 0, 1);
        step(0, 0, 0, 0, 0, 1'b0);
        idle(0);
        chk("mrst_valid", 32'(bus.frame_valid_o), 32'd0);
        chk("mrst_err", 32'(bus.err_o), 32'd0);
        rand_frame(0);
        idle(0);
        chk("mrst_frame", 32'(bus.frame_valid_o), 32'd1);
        idle(1);

        // Random traffic
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 40) == 0), ($urandom_range(0, 2) != 0), 1);
        idle(1);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
